// File: rtl/fifo_mc_pkg.sv
// fifo_mc_pkg: sizing helpers shared by the multi-channel FIFO and its bench
package fifo_mc_pkg;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
  function automatic int ch_bits_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  // pointers and counts carry one wrap bit above the slot index
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: synchronous-write RAM with a 1-cycle registered read port
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc: NUM_CH logical FIFOs sharing one dual_port_ram, one write and one read per cycle.
// Optional almost_full/almost_empty flags under FIFO_MC_ALMOST_FLAGS_EN.
module fifo_sync_mc
  import fifo_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 4,
  parameter int CH_BITS    = ch_bits_of(NUM_CH)
`ifdef FIFO_MC_ALMOST_FLAGS_EN
  , parameter int AF_LEVEL = depth_of(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [CH_BITS-1:0]    wr_ch,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic                  rd_en,
  input  logic [CH_BITS-1:0]    rd_ch,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic [NUM_CH-1:0]     full,
  output logic [NUM_CH-1:0]     empty,
  output logic                  wr_err,
  output logic                  rd_err
`ifdef FIFO_MC_ALMOST_FLAGS_EN
  , output logic [NUM_CH-1:0]   almost_full,
  output logic [NUM_CH-1:0]     almost_empty
`endif
);
  localparam int CW = cnt_w(ADDR_WIDTH);
  logic [NUM_CH-1:0] wr_sel, rd_sel;
  logic [ADDR_WIDTH-1:0] wr_lo [NUM_CH];
  logic [ADDR_WIDTH-1:0] rd_lo [NUM_CH];
  logic [ADDR_WIDTH-1:0] wr_slot, rd_slot;
  logic [DATA_WIDTH-1:0] ram_q, hold;
  logic wr_ok, rd_ok;
  // an out-of-range channel selects nothing, so it is refused like a full/empty one
  assign wr_ok = wr_en && |(wr_sel & ~full);
  assign rd_ok = rd_en && |(rd_sel & ~empty);
  always_comb begin
    wr_slot = '0;
    rd_slot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_slot = wr_sel[i] ? wr_lo[i] : wr_slot;
      rd_slot = rd_sel[i] ? rd_lo[i] : rd_slot;
    end
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] wp, rp, wp_n, rp_n;
    logic full_q, empty_q;
    assign wr_sel[c] = wr_ch == CH_BITS'(c);
    assign rd_sel[c] = rd_ch == CH_BITS'(c);
    assign wp_n = wp + CW'(wr_ok & wr_sel[c]);
    assign rp_n = rp + CW'(rd_ok & rd_sel[c]);
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        wp      <= '0;
        rp      <= '0;
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        wp      <= wp_n;
        rp      <= rp_n;
        full_q  <= wp_n == {~rp_n[CW-1], rp_n[CW-2:0]};
        empty_q <= wp_n == rp_n;
      end
    end
    assign full[c]  = full_q;
    assign empty[c] = empty_q;
    assign wr_lo[c] = wp[ADDR_WIDTH-1:0];
    assign rd_lo[c] = rp[ADDR_WIDTH-1:0];
`ifdef FIFO_MC_ALMOST_FLAGS_EN
    logic [CW-1:0] cnt_n;
    logic af_q, ae_q;
    assign cnt_n = wp_n - rp_n;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        af_q <= 1'b0;
        ae_q <= 1'b1;
      end else begin
        af_q <= cnt_n >= CW'(AF_LEVEL);
        ae_q <= cnt_n <= CW'(AE_LEVEL);
      end
    end
    assign almost_full[c]  = af_q;
    assign almost_empty[c] = ae_q;
`endif
  end
  dual_port_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(CH_BITS + ADDR_WIDTH)) u_ram (
    .clk(clk),
    .we(wr_ok),
    .waddr({wr_ch, wr_slot}),
    .wdata(wrdata),
    .re(rd_ok),
    .raddr({rd_ch, rd_slot}),
    .q(ram_q)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
      hold     <= '0;
    end else begin
      rd_valid <= rd_ok;
      wr_err   <= wr_en && !wr_ok;
      rd_err   <= rd_en && !rd_ok;
      hold     <= rd_valid ? ram_q : hold;
    end
  end
  // the RAM output register is unreset, so idle cycles show the last delivered word
  assign rdata = rd_valid ? ram_q : hold;
endmodule
